// File: rtl/mem_dp_be.sv
// Simple-dual-port byte-enabled RAM with post-reset clearing FSM, range checking and selectable read-during-write.
// Optional macro MEM_OUT_REG_EN adds a second output register stage (read latency 2).
module mem_dp_be #(
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_W     = 8,
  parameter int MAX_ADR    = 100,
  parameter int ADDRSIZE   = $clog2(MAX_ADR),
  parameter int RDW_MODE   = 0,
  parameter int NBE        = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDRSIZE-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [NBE-1:0]        wr_be,
  input  logic [ADDRSIZE-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  err_addr
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  // One extra bit so a power-of-two MAX_ADR is representable.
  localparam logic [ADDRSIZE:0]   ADR_LIMIT = (ADDRSIZE + 1)'(MAX_ADR);
  localparam logic [ADDRSIZE-1:0] LAST_ADR  = ADDRSIZE'(MAX_ADR - 1);

  state_t                state, state_nxt;
  logic [ADDRSIZE-1:0]   init_cnt, init_cnt_nxt;
  logic [DATA_WIDTH-1:0] mem [MAX_ADR];

  logic                  rd_ok, wr_ok, rd_req, wr_req, rd_hit;
  logic [DATA_WIDTH-1:0] rd_old, rd_word;
  logic [DATA_WIDTH-1:0] rd_data_p0;
  logic                  vld_p0, err_p0;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NBE-1:0]        be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NBE; i++)
      if (be[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      ST_INIT: begin
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == LAST_ADR) state_nxt = ST_READY;
      end
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_INIT;
    endcase
  end

  assign busy = (state == ST_INIT);

  always_comb begin
    rd_ok   = {1'b0, rd_addr} < ADR_LIMIT;
    wr_ok   = {1'b0, wr_addr} < ADR_LIMIT;
    rd_req  = rd_en && (state == ST_READY);
    wr_req  = wr_en && (state == ST_READY);
    rd_hit  = wr_req && wr_ok && (wr_addr == rd_addr);
    rd_old  = rd_ok ? mem[rd_addr] : '0;
    rd_word = (RDW_MODE != 0 && rd_hit) ? merge_lanes(rd_old, wr_data, wr_be) : rd_old;
  end

  // Array has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (rst_n && state == ST_INIT) begin
      mem[init_cnt] <= '0;
    end else if (rst_n && wr_req && wr_ok) begin
      for (int i = 0; i < NBE; i++)
        if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
    end
  end

  // Stage p0: first output register, read-during-write resolved here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_p0 <= '0;
      vld_p0     <= 1'b0;
      err_p0     <= 1'b0;
    end else begin
      vld_p0 <= rd_req;
      err_p0 <= (rd_req && !rd_ok) || (wr_req && !wr_ok);
      if (rd_req) rd_data_p0 <= rd_word;
    end
  end

  assign err_addr = err_p0;

`ifdef MEM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;

  // Stage p1: optional output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      rd_data_p1 <= rd_data_p0;
      vld_p1     <= vld_p0;
    end
  end

  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;
`else
  assign rd_data  = rd_data_p0;
  assign rd_valid = vld_p0;
`endif

endmodule

// File: tb/tb_mem_dp_be.sv
// Randomised bench for mem_dp_be: two instances (old-data and new-data read-during-write)
// checked every cycle against a word-array model, plus literal spot checks.
module tb_mem_dp_be;
  localparam int DW  = 16;
  localparam int BW  = 8;
  localparam int MAX = 100;
  localparam int AW  = $clog2(MAX);
  localparam int NBE = DW / BW;
`ifdef MEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk, rst_n;
  logic          rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [NBE-1:0] wr_be;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, busy0, busy1, err0, err1;

  mem_dp_be #(.DATA_WIDTH(DW), .BYTE_W(BW), .MAX_ADR(MAX), .RDW_MODE(0)) u_old (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy0), .err_addr(err0));

  mem_dp_be #(.DATA_WIDTH(DW), .BYTE_W(BW), .MAX_ADR(MAX), .RDW_MODE(1)) u_new (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy1), .err_addr(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] m_mem [MAX];
  int            m_busy_left;
  logic [DW-1:0] s1_d0, s1_d1, s2_d0, s2_d1;
  logic          s1_v, s1_err, s2_v;
  logic [DW-1:0] e_d0, e_d1;
  logic          e_v, e_err, e_busy;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [NBE-1:0] be);
    logic [DW-1:0] mask;
    mask = '0;
    for (int i = 0; i < NBE; i++)
      if (be[i]) mask[i*BW +: BW] = '1;
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] old_w;
    logic rok, wok;
    if (!rst_n) begin
      m_busy_left = MAX;
      for (int a = 0; a < MAX; a++) m_mem[a] = '0;
      s1_d0 = '0; s1_d1 = '0; s1_v = 1'b0; s1_err = 1'b0;
      s2_d0 = '0; s2_d1 = '0; s2_v = 1'b0;
    end else begin
      s2_d0 = s1_d0; s2_d1 = s1_d1; s2_v = s1_v;
      if (m_busy_left > 0) begin
        m_busy_left--;
        s1_v = 1'b0; s1_err = 1'b0;
      end else begin
        rok  = int'(rd_addr) < MAX;
        wok  = int'(wr_addr) < MAX;
        s1_v = rd_en;
        if (rd_en) begin
          if (rok) begin
            old_w = m_mem[rd_addr];
            s1_d0 = old_w;
            s1_d1 = (wr_en && wok && wr_addr == rd_addr) ? merge(old_w, wr_data, wr_be) : old_w;
          end else begin
            s1_d0 = '0; s1_d1 = '0;
          end
        end
        s1_err = (rd_en && !rok) || (wr_en && !wok);
        if (wr_en && wok) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
      end
    end
    if (LAT == 2) begin
      e_d0 = s2_d0; e_d1 = s2_d1; e_v = s2_v;
    end else begin
      e_d0 = s1_d0; e_d1 = s1_d1; e_v = s1_v;
    end
    e_err  = s1_err;
    e_busy = m_busy_left > 0;
  endtask

  task automatic compare_all();
    chk("busy0", 32'(busy0), 32'(e_busy));
    chk("busy1", 32'(busy1), 32'(e_busy));
    chk("err0", 32'(err0), 32'(e_err));
    chk("err1", 32'(err1), 32'(e_err));
    chk("valid0", 32'(rd_valid0), 32'(e_v));
    chk("valid1", 32'(rd_valid1), 32'(e_v));
    chk("data0", 32'(rd_data0), 32'(e_d0));
    chk("data1", 32'(rd_data1), 32'(e_d1));
  endtask

  task automatic step(input logic re, input logic [AW-1:0] ra, input logic we,
                      input logic [NBE-1:0] be, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    rd_en = re; rd_addr = ra; wr_en = we; wr_be = be; wr_addr = wa; wr_data = wd;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input int a);
    step(1'b1, AW'(a), 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input int a, input logic [NBE-1:0] be, input logic [DW-1:0] d);
    step(1'b0, '0, 1'b1, be, AW'(a), d);
  endtask

  task automatic settle();
    repeat (LAT - 1) idle();
  endtask

  task automatic lit(input string nm, input logic [DW-1:0] exp0, input logic [DW-1:0] exp1);
    chk({nm, "_dut0"}, 32'(rd_data0), 32'(exp0));
    chk({nm, "_dut1"}, 32'(rd_data1), 32'(exp1));
    chk({nm, "_vld"}, 32'(rd_valid0), 32'd1);
    chk({nm, "_model"}, 32'(e_d0), 32'(exp0));
  endtask

  task automatic rand_op(input bit allow);
    logic re, we;
    logic [AW-1:0] ra, wa;
    re = allow ? 1'($urandom_range(0, 1)) : 1'b0;
    we = allow ? 1'($urandom_range(0, 1)) : 1'b0;
    ra = AW'($urandom_range(0, 127));
    wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 127));
    step(re, ra, we, NBE'($urandom_range(0, 3)), wa, DW'($urandom));
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0; rd_addr = '0; wr_addr = '0; wr_be = '0; wr_data = '0;
    repeat (3) idle();
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_valid", 32'(rd_valid0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_data", 32'(rd_data0), 32'd0);
    rst_n = 1'b1;

    cnt = 0;
    while (busy0 && cnt < 200) begin
      cnt++;
      idle();
    end
    chk("busy_len", 32'(cnt), 32'd100);

    rd(99); settle();
    lit("rd99", 16'h0000, 16'h0000);

    wr(5, 2'b11, 16'hABCD);
    rd(5); settle();
    lit("rd5_full", 16'hABCD, 16'hABCD);

    wr(5, 2'b01, 16'h1234);
    rd(5); settle();
    lit("rd5_lane", 16'hAB34, 16'hAB34);

    wr(7, 2'b11, 16'h1111);
    step(1'b1, AW'(7), 1'b1, 2'b11, AW'(7), 16'h2222); settle();
    lit("rdw7", 16'h1111, 16'h2222);
    rd(7); settle();
    lit("rd7_after", 16'h2222, 16'h2222);

    rd(100);
    chk("err_rd100", 32'(err0), 32'd1);
    settle();
    lit("rd100", 16'h0000, 16'h0000);

    wr(127, 2'b11, 16'hFFFF);
    chk("err_wr127", 32'(err0), 32'd1);

    for (int a = 0; a < MAX; a++) rd(a);
    repeat (LAT) idle();

    for (int n = 0; n < 400; n++) rand_op(1'b1);

    for (int a = 0; a < MAX; a++) rd(a);
    repeat (LAT) idle();

    // Reset in the middle of INIT, with traffic during the clearing sweep
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    repeat (40) idle();
    rst_n = 1'b0;
    rand_op(1'b1);
    rst_n = 1'b1;
    cnt = 0;
    while (busy0 && cnt < 200) begin
      cnt++;
      rand_op(1'b1);
    end
    chk("busy_len_restart", 32'(cnt), 32'd100);
    idle();

    for (int a = 0; a < MAX; a++) rd(a);
    repeat (LAT) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
